// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio level reader.
//   state_e      - reader FSM state encoding
//   SAMPLE_W     - codec sample width (signed two's complement)
//   MAG_W        - saturated magnitude width
//   LEVEL_W      - reported level width (top bits of the peak magnitude)
//   DEF_*        - default window length and loud thresholds
//   mix_mag()    - average of two magnitudes without overflow
package audio_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_ACK  = 2'd1,
    ST_PROC = 2'd2
  } state_e;

  localparam int SAMPLE_W = 28;
  localparam int MAG_W    = 27;
  localparam int LEVEL_W  = 8;

  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_THRESH_HI = 96;
  localparam int DEF_THRESH_LO = 64;

  // The sum is formed one bit wider than a magnitude so it cannot wrap;
  // dropping the LSB brings the average back to MAG_W bits exactly.
  function automatic logic [MAG_W-1:0] mix_mag(input logic [MAG_W-1:0] mag_a,
                                               input logic [MAG_W-1:0] mag_b);
    logic [MAG_W:0] sum;
    sum = {1'b0, mag_a} + {1'b0, mag_b};
    return sum[MAG_W:1];
  endfunction

endpackage

// File: rtl/audio_level_reader_if.sv
// audio_level_reader_if: codec ADC FIFO read handshake.
//   read_ready      - codec FIFO holds a sample
//   readdata_left   - signed left sample, valid while read_ready=1
//   readdata_right  - signed right sample, valid while read_ready=1
//   read            - one-cycle pop strobe from the reader
// Modports: master = level reader (issues read), slave = codec side.
interface audio_level_reader_if;
  import audio_pkg::*;

  logic                read_ready;
  logic [SAMPLE_W-1:0] readdata_left;
  logic [SAMPLE_W-1:0] readdata_right;
  logic                read;

  modport master (
    input  read_ready,
    input  readdata_left,
    input  readdata_right,
    output read
  );

  modport slave (
    output read_ready,
    output readdata_left,
    output readdata_right,
    input  read
  );

endinterface

// File: rtl/audio_level_reader_abs_sat.sv
// abs_sat: combinational saturated magnitude of a signed sample.
//   x   - SAMPLE_W-bit signed two's-complement input
//   mag - MAG_W-bit magnitude; the most negative input saturates to all ones
module abs_sat
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] x,
  output logic [MAG_W-1:0]    mag
);

  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

  always_comb begin
    mag = x[MAG_W-1:0];
    if (x[SAMPLE_W-1]) begin
      // -2^(SAMPLE_W-1) has no positive counterpart in MAG_W bits.
      if (x == MOST_NEG) begin
        mag = {MAG_W{1'b1}};
      end else begin
        mag = MAG_W'(-x);
      end
    end
  end

endmodule

// File: rtl/audio_level_reader.sv
// audio_level_reader: pops stereo samples from a codec ADC FIFO, tracks the
// peak of the averaged channel magnitudes over WINDOW samples and reports it
// as an 8-bit level with a hysteresis-filtered loud flag.
//   clk         - system clock, rising edge
//   resetn      - asynchronous active-low reset
//   enable      - allow new reads; an in-flight sample always completes
//   codec       - FIFO read handshake (master side)
//   level       - peak magnitude [26:19] of the last completed window
//   level_valid - one-cycle pulse when level updates
//   loud        - set at level >= THRESH_HI, cleared at level < THRESH_LO
//
// state | meaning
// WAIT  | idle; on enable & read_ready capture both channels, raise read
// ACK   | read high for this cycle only; captured data stable
// PROC  | fold the captured sample into peak/counter, close window if due
module audio_level_reader
  import audio_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int THRESH_HI = DEF_THRESH_HI,
  parameter int THRESH_LO = DEF_THRESH_LO
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  audio_level_reader_if.master codec,
  output logic [LEVEL_W-1:0]   level,
  output logic                 level_valid,
  output logic                 loud
);

  localparam int                 CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [LEVEL_W-1:0] HI_LVL   = LEVEL_W'(THRESH_HI);
  localparam logic [LEVEL_W-1:0] LO_LVL   = LEVEL_W'(THRESH_LO);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] cap_l_q, cap_l_d;
  logic [SAMPLE_W-1:0] cap_r_q, cap_r_d;
  logic                read_q, read_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAG_W-1:0]    peak_q, peak_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                level_valid_q, level_valid_d;
  logic                loud_q, loud_d;

  logic [MAG_W-1:0]    mag_l, mag_r;
  logic [MAG_W-1:0]    mix;
  logic [MAG_W-1:0]    peak_new;
  logic                take;

  abs_sat u_abs_l (.x(cap_l_q), .mag(mag_l));
  abs_sat u_abs_r (.x(cap_r_q), .mag(mag_r));

  assign mix      = mix_mag(mag_l, mag_r);
  assign peak_new = (mix > peak_q) ? mix : peak_q;
  assign take     = enable && codec.read_ready;

  // State register (all flops share the asynchronous clear).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_WAIT;
      cap_l_q       <= '0;
      cap_r_q       <= '0;
      read_q        <= 1'b0;
      cnt_q         <= '0;
      peak_q        <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      loud_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_l_q       <= cap_l_d;
      cap_r_q       <= cap_r_d;
      read_q        <= read_d;
      cnt_q         <= cnt_d;
      peak_q        <= peak_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      loud_q        <= loud_d;
    end
  end

  // Next-state logic. ACK and PROC advance unconditionally so a dropped
  // enable or read_ready never strands a sample half-processed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (take) state_d = ST_ACK;
      ST_ACK:  state_d = ST_PROC;
      ST_PROC: state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    cap_l_d       = cap_l_q;
    cap_r_d       = cap_r_q;
    read_d        = 1'b0;
    cnt_d         = cnt_q;
    peak_d        = peak_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    loud_d        = loud_q;

    case (state_q)
      ST_WAIT: begin
        if (take) begin
          cap_l_d = codec.readdata_left;
          cap_r_d = codec.readdata_right;
          read_d  = 1'b1;
        end
      end
      ST_PROC: begin
        if (cnt_q == CNT_LAST) begin
          level_d       = peak_new[MAG_W-1 -: LEVEL_W];
          level_valid_d = 1'b1;
          peak_d        = '0;
          cnt_d         = '0;
          // Between the two thresholds the previous decision stands.
          if (level_d >= HI_LVL) begin
            loud_d = 1'b1;
          end else if (level_d < LO_LVL) begin
            loud_d = 1'b0;
          end
        end else begin
          peak_d = peak_new;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign codec.read  = read_q;
  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign loud        = loud_q;

endmodule

// File: doc/audio_level_reader.md
AUDIO_LEVEL_READER -- requirements
Module: audio_level_reader

Interface
REQ-001 SHALL have parameter WINDOW, default 1024; number of samples per measurement window (range 2..65536).
REQ-002 SHALL have parameter THRESH_HI, default 96; 8-bit level at or above which loud sets.
REQ-003 SHALL have parameter THRESH_LO, default 64; 8-bit level below which loud clears.
REQ-004 clk  in  1  system clock (CLOCK_50 domain); one clock; all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high: accept new samples; low: issue no new reads.
REQ-007 read_ready  in  1  codec ADC FIFO holds a sample.
REQ-008 readdata_left  in  28  signed two's-complement left sample, valid while read_ready=1.
REQ-009 readdata_right  in  28  signed two's-complement right sample, valid while read_ready=1.
REQ-010 read  out  1  one-cycle pop strobe to codec.
REQ-011 level  out  8  peak magnitude of last completed window.
REQ-012 level_valid  out  1  one-cycle pulse when level updates.
REQ-013 loud  out  1  hysteresis-filtered level-above-threshold flag.

Function
REQ-014 FSM SHALL have states WAIT, ACK, PROC; reset state WAIT.
REQ-015 In WAIT with enable=1 and read_ready=1, at the clock edge: capture both channels, set read=1, go to ACK.
REQ-016 In ACK: read=0 at next edge, go to PROC unconditionally (read high exactly one cycle; at least one idle cycle before next read).
REQ-017 In PROC: update peak/counter/outputs at the edge, return to WAIT; maximum throughput one sample per 3 cycles.
REQ-018 Magnitude per channel SHALL be |x| in 27 bits; -2^27 saturates to 2^27-1.
REQ-019 mix SHALL be (|L|+|R|)>>1, computed in 28 bits without overflow, truncated to 27 bits.
REQ-020 peak SHALL become max(peak, mix); sample counter SHALL increment per PROC.
REQ-021 When the counter equals WINDOW-1 in PROC: level <= max(peak,mix)[26:19], level_valid <= 1 for one cycle, peak <= 0, counter <= 0.
REQ-022 loud SHALL update only on window completion: set if new level >= THRESH_HI, clear if new level < THRESH_LO, otherwise hold.
REQ-023 enable falling mid-transaction SHALL NOT abort ACK/PROC; counter and peak hold while enable=0.
REQ-024 read_ready dropping during ACK or PROC SHALL have no effect; captured data is used.
REQ-025 level and loud SHALL hold between windows.

Reset
REQ-026 resetn=0 SHALL immediately force read=0, level=0, level_valid=0, loud=0, state WAIT, counter=0, peak=0, capture registers=0.
REQ-027 Reset asserted mid-transaction SHALL discard the in-flight sample; first post-reset read requires a fresh WAIT qualification.

Structure
REQ-028 Shared package/include audio_pkg SHALL hold the FSM state encoding, SAMPLE_W=28, MAG_W=27, and default WINDOW/THRESH values.
REQ-029 One sub-module abs_sat (28-bit signed in, 27-bit saturated magnitude out, combinational) SHALL be instantiated twice.
REQ-030 Counter width SHALL be $clog2(WINDOW).

Verification
REQ-031 Reset: hold resetn=0 with read_ready=1 -> read, level, level_valid, loud all 0; no read pulse until 1 cycle after release.
REQ-032 Handshake: WINDOW=4, read_ready held 1, enable=1 -> read pulses 1 cycle every 3 cycles; level_valid once per 4 reads, at the PROC edge of the 4th.
REQ-033 Level: L=R=0x4000000 for one window -> level=128, loud=1.
REQ-034 Saturation: L=R=0x8000000 (-2^27) -> level=255; L=0x7FFFFFF, R=0x8000000 -> level=255.
REQ-035 Hysteresis: windows with level 128, 80, 32 -> loud 1, 1, 0; then 70 -> loud stays 0.
REQ-036 Mid-op events: drop enable in ACK -> that sample completes, no further read; resetn low in ACK -> read=0 immediately, counter=0, next window needs full WINDOW samples.
